ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ADDR_SIZE, 8, RAM address width.
- MEM_WIDTH, 8, RAM data width.
- RD_TIMEOUT, 4, max cycles to wait for ram_tx_valid after a read-data command.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all logic rising-edge.
- rst, in, 1, synchronous, active-high reset.
- req0_valid, in, 1, requester 0 command valid.
- req0_cmd, in, 10, requester 0 command: [9:8] opcode, [7:0] payload.
- req0_ready, out, 1, requester 0 command accepted this cycle.
- req0_rvalid, out, 1, one-cycle read-data pulse to requester 0.
- req0_rdata, out, MEM_WIDTH, read data to requester 0.
- req1_valid / req1_cmd / req1_ready / req1_rvalid / req1_rdata, as req0, for requester 1.
- ram_rx_valid, out, 1, command strobe to the RAM.
- ram_rx_data, out, 10, command to the RAM.
- ram_tx_valid, in, 1, RAM read data valid.
- ram_dout, in, MEM_WIDTH, RAM read data.
- owner, out, 1, index of the requester holding or last holding the grant.
- busy, out, 1, high when state is not IDLE.
- timeout_err, out, 1, one-cycle pulse on read timeout.

Function
REQ-003 Opcodes: 00 write-address, 01 write-data, 10 read-address, 11 read-data.
REQ-004 States: IDLE, OWN (transaction locked to owner), RD_WAIT (awaiting RAM read data).
REQ-005 Round-robin priority pointer (rr_ptr) selects the winner when both requesters are valid in IDLE. When only one is valid, that requester wins.
REQ-006 reqN_ready is combinational:
- IDLE: high for the winner only.
- OWN: high for the owner only.
- RD_WAIT: low for both.
REQ-007 A handshake (valid & ready) registers the command. The next cycle, ram_rx_valid=1 and ram_rx_data=cmd. Latency is exactly 1 cycle. ram_rx_valid is high only in cycles that follow a handshake.
REQ-008 On handshake, owner is set to the accepted requester.
REQ-009 Address commands (00 or 10), accepted in IDLE or OWN, move the state to OWN. While in OWN, the other requester's ready stays 0.
REQ-010 A write-data command (01) ends the transaction: state goes to IDLE and rr_ptr is set to the non-owner.
REQ-011 A read-data command (11) moves the state to RD_WAIT and starts the timeout counter at 0.
REQ-012 RD_WAIT behaviour:
- The counter increments each cycle after ram_rx_valid.
- On ram_tx_valid: the owner's rdata is loaded with ram_dout, its rvalid pulses for 1 cycle (the cycle after tx_valid), state goes to IDLE, and rr_ptr is set to the non-owner.
REQ-013 If RD_TIMEOUT cycles elapse in RD_WAIT without ram_tx_valid: timeout_err pulses for 1 cycle, no rvalid is issued, rdata is unchanged, state goes to IDLE, and rr_ptr is set to the non-owner.
REQ-014 Data command accepted in IDLE with no preceding address: it is forwarded unchanged. A 01 command follows REQ-010 and a 11 command follows REQ-011.
REQ-015 ram_tx_valid outside RD_WAIT is ignored: no rvalid is issued and rdata is unchanged.
REQ-016 ram_tx_valid in the same cycle the timeout would fire takes precedence; timeout_err is not asserted.
REQ-017 rdata holds its last value until the next rvalid for that requester.
REQ-018 A requester deasserting valid while owning in OWN keeps the lock; the other requester remains blocked.

Reset
REQ-019 When rst=1 at a clock edge, the following take effect next cycle regardless of state:
- state=IDLE, rr_ptr=0, owner=0, busy=0.
- ram_rx_valid=0, ram_rx_data=0.
- req0/1_rvalid=0, req0/1_rdata=0.
- timeout_err=0, timeout counter=0.
REQ-020 Reset mid-transaction (OWN or RD_WAIT) discards the transaction. A RAM tx_valid arriving after reset is ignored per REQ-015.

Verification
REQ-021 Write, req0: cmd 0x005 then 0x1A5 → ram_rx_data 0x005 then 0x1A5, each 1 cycle after its handshake; state returns to IDLE and rr_ptr=1.
REQ-022 Contention: both requesters valid in IDLE after reset → req0 granted. After req0's write completes with both still valid → req1 granted next.
REQ-023 Lock: req0 sends 0x210 (read-address) while req1 is continuously valid → req1_ready stays 0 until req0's read completes.
REQ-024 Read, req1: cmd 0x220 then 0x300, and the RAM returns tx_valid with dout=0x5C 2 cycles after the 0x300 forward → req1_rvalid pulses once, req1_rdata=0x5C, req0_rvalid stays 0.
REQ-025 Timeout: read-data forwarded with no tx_valid → timeout_err pulses exactly RD_TIMEOUT cycles after the forward; no rvalid; state returns to IDLE. A late tx_valid is ignored.
REQ-026 Reset in RD_WAIT → all outputs 0 next cycle, busy=0, a subsequent tx_valid produces no rvalid, and req0 wins the next contention.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of a single RAM command port.
// An address command locks the RAM to its requester until the matching
// data command finishes. A write-data command ends the transaction at once.
// A read-data command ends it when the RAM returns data or when a timeout fires.
//
// Handshake: a command transfers on a rising edge where reqN_valid and
// reqN_ready are both high. ready is combinational and never depends on
// anything the requester drives other than the two valids. The RAM side
// has no backpressure: ram_rx_valid is a single-cycle strobe. ram_tx_valid
// is a single-cycle strobe that matters only while a read is outstanding.
module ram_port_arbiter #(
   parameter int ADDR_SIZE  = 8,
   parameter int MEM_WIDTH  = 8,
   parameter int RD_TIMEOUT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req0_valid,
   input  logic [9:0]           req0_cmd,
   output logic                 req0_ready,
   output logic                 req0_rvalid,
   output logic [MEM_WIDTH-1:0] req0_rdata,
   input  logic                 req1_valid,
   input  logic [9:0]           req1_cmd,
   output logic                 req1_ready,
   output logic                 req1_rvalid,
   output logic [MEM_WIDTH-1:0] req1_rdata,
   output logic                 ram_rx_valid,
   output logic [9:0]           ram_rx_data,
   input  logic                 ram_tx_valid,
   input  logic [MEM_WIDTH-1:0] ram_dout,
   output logic                 owner,
   output logic                 busy,
   output logic                 timeout_err,
   output logic [1:0]           dbg_state
);

   // The address width is carried inside the command payload; it is kept
   // as a parameter so the port description stays complete.
   localparam int CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OWN     = 2'd1,
      RD_WAIT = 2'd2
   } state_t;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   state_t               state_q, state_d;
   logic                 rr_q, rr_d;
   logic                 owner_q, owner_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 rx_valid_q, rx_valid_d;
   logic [9:0]           rx_data_q, rx_data_d;
   logic                 rvalid0_q, rvalid0_d;
   logic                 rvalid1_q, rvalid1_d;
   logic [MEM_WIDTH-1:0] rdata0_q, rdata0_d;
   logic [MEM_WIDTH-1:0] rdata1_q, rdata1_d;
   logic                 tmo_q, tmo_d;

   logic                 win_idx;
   logic                 any_valid;
   logic                 hs0, hs1, hs, hs_idx;
   logic [9:0]           hs_cmd;

   // Grant selection and the handshake it produces.
   always_comb begin
      any_valid  = req0_valid | req1_valid;
      // With both requesters asking, the round-robin pointer decides;
      // otherwise whoever is asking wins.
      win_idx    = (req0_valid & req1_valid) ? rr_q : req1_valid;
      req0_ready = ((state_q == IDLE) & any_valid & ~win_idx) |
                   ((state_q == OWN) & ~owner_q);
      req1_ready = ((state_q == IDLE) & any_valid & win_idx) |
                   ((state_q == OWN) & owner_q);
      hs0        = req0_valid & req0_ready;
      hs1        = req1_valid & req1_ready;
      hs         = hs0 | hs1;
      hs_idx     = hs1;
      hs_cmd     = hs1 ? req1_cmd : req0_cmd;
   end

   // Next-state and registered-output computation for the transaction FSM.
   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      rx_valid_d = 1'b0;
      rx_data_d  = rx_data_q;
      rvalid0_d  = 1'b0;
      rvalid1_d  = 1'b0;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;
      tmo_d      = 1'b0;

      if (hs) begin
         rx_valid_d = 1'b1;
         rx_data_d  = hs_cmd;
         owner_d    = hs_idx;
         case (hs_cmd[9:8])
            OP_WR_ADDR, OP_RD_ADDR: state_d = OWN;
            OP_WR_DATA: begin
               state_d = IDLE;
               rr_d    = ~hs_idx;
            end
            OP_RD_DATA: begin
               state_d = RD_WAIT;
               cnt_d   = '0;
            end
            default: state_d = state_q;
         endcase
      end else if (state_q == RD_WAIT) begin
         // Returning data wins over a timeout that would fire this cycle.
         if (ram_tx_valid) begin
            if (owner_q) begin
               rvalid1_d = 1'b1;
               rdata1_d  = ram_dout;
            end else begin
               rvalid0_d = 1'b1;
               rdata0_d  = ram_dout;
            end
            state_d = IDLE;
            rr_d    = ~owner_q;
         end else if (cnt_q == CNT_LAST) begin
            tmo_d   = 1'b1;
            state_d = IDLE;
            rr_d    = ~owner_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rr_q       <= 1'b0;
         owner_q    <= 1'b0;
         cnt_q      <= '0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= '0;
         rvalid0_q  <= 1'b0;
         rvalid1_q  <= 1'b0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
         tmo_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q  <= rx_data_d;
         rvalid0_q  <= rvalid0_d;
         rvalid1_q  <= rvalid1_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
         tmo_q      <= tmo_d;
      end
   end

   assign ram_rx_valid = rx_valid_q;
   assign ram_rx_data  = rx_data_q;
   assign req0_rvalid  = rvalid0_q;
   assign req1_rvalid  = rvalid1_q;
   assign req0_rdata   = rdata0_q;
   assign req1_rdata   = rdata1_q;
   assign timeout_err  = tmo_q;
   assign owner        = owner_q;
   assign busy         = (state_q != IDLE);
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter. The driver pushes expected RAM
// commands, read returns and timeouts, each tagged with its cycle, into queues.
// A negedge monitor pops from those queues whenever the DUT strobes an output.
module tb_ram_port_arbiter;

   localparam int MW  = 8;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req0_valid = 1'b0;
   logic [9:0]    req0_cmd = '0;
   logic          req0_ready, req0_rvalid;
   logic [MW-1:0] req0_rdata;
   logic          req1_valid = 1'b0;
   logic [9:0]    req1_cmd = '0;
   logic          req1_ready, req1_rvalid;
   logic [MW-1:0] req1_rdata;
   logic          ram_rx_valid;
   logic [9:0]    ram_rx_data;
   logic          ram_tx_valid = 1'b0;
   logic [MW-1:0] ram_dout = '0;
   logic          owner, busy, timeout_err;
   logic [1:0]    dbg_state;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   logic [9:0] exp_rx_q[$];
   int         exp_rx_cyc_q[$];
   logic [8:0] exp_rd_q[$];
   int         exp_rd_cyc_q[$];
   int         exp_tmo_q[$];

   ram_port_arbiter #(.ADDR_SIZE(8), .MEM_WIDTH(MW), .RD_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_ready(req0_ready),
      .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
      .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_ready(req1_ready),
      .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
      .ram_rx_valid(ram_rx_valid), .ram_rx_data(ram_rx_data),
      .ram_tx_valid(ram_tx_valid), .ram_dout(ram_dout),
      .owner(owner), .busy(busy), .timeout_err(timeout_err),
      .dbg_state(dbg_state)
   );

   // Clock and cycle counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors = vectors + 1;
      if (act !== exp) begin
         miscompares = miscompares + 1;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Call when the inputs now applied will handshake at the coming edge.
   task automatic expect_fwd(input logic [9:0] cmd);
      exp_rx_q.push_back(cmd);
      exp_rx_cyc_q.push_back(cyc + 1);
   endtask

   task automatic expect_rd(input logic idx, input logic [7:0] data, input int at_cyc);
      exp_rd_q.push_back({idx, data});
      exp_rd_cyc_q.push_back(at_cyc);
   endtask

   task automatic chk_ready(input string name, input logic r0, input logic r1);
      chk({name, "_ready0"}, 32'(req0_ready), 32'(r0));
      chk({name, "_ready1"}, 32'(req1_ready), 32'(r1));
   endtask

   // Scoreboard monitor for every strobed DUT output.
   always @(negedge clk) begin
      if (ram_rx_valid) begin
         if (exp_rx_q.size() == 0) begin
            chk("rx_unexpected", 32'(ram_rx_data), 32'h3ff);
         end else begin
            chk("rx_data", 32'(ram_rx_data), 32'(exp_rx_q.pop_front()));
            chk("rx_cycle", 32'(cyc), 32'(exp_rx_cyc_q.pop_front()));
         end
      end
      if (req0_rvalid || req1_rvalid) begin
         if (exp_rd_q.size() == 0) begin
            chk("rvalid_unexpected", {30'd0, req1_rvalid, req0_rvalid}, 32'd0);
         end else begin
            chk("rvalid_both", 32'(req0_rvalid & req1_rvalid), 32'd0);
            chk("rd_resp", {23'd0, req1_rvalid, req1_rvalid ? req1_rdata : req0_rdata},
                32'(exp_rd_q.pop_front()));
            chk("rd_cycle", 32'(cyc), 32'(exp_rd_cyc_q.pop_front()));
         end
      end
      if (timeout_err) begin
         if (exp_tmo_q.size() == 0) chk("tmo_unexpected", 32'd1, 32'd0);
         else chk("tmo_cycle", 32'(cyc), 32'(exp_tmo_q.pop_front()));
      end
   end

   task automatic chk_reset_state(input string name);
      chk({name, "_busy"}, 32'(busy), 32'd0);
      chk({name, "_owner"}, 32'(owner), 32'd0);
      chk({name, "_rx_valid"}, 32'(ram_rx_valid), 32'd0);
      chk({name, "_rx_data"}, 32'(ram_rx_data), 32'd0);
      chk({name, "_rdata0"}, 32'(req0_rdata), 32'd0);
      chk({name, "_rdata1"}, 32'(req1_rdata), 32'd0);
      chk({name, "_rvalid"}, {30'd0, req1_rvalid, req0_rvalid}, 32'd0);
      chk({name, "_tmo"}, 32'(timeout_err), 32'd0);
      chk({name, "_state"}, 32'(dbg_state), 32'd0);
   endtask

   // Directed stimulus.
   initial begin
      int f;
      tick(); tick();
      rst = 1'b0;
      settle();
      chk_reset_state("reset");

      // Contention after reset: req0 wins, holds the lock, then req1 wins.
      req0_valid = 1'b1; req0_cmd = 10'h005;
      req1_valid = 1'b1; req1_cmd = 10'h0AA;
      settle();
      chk_ready("cont0", 1'b1, 1'b0);
      expect_fwd(10'h005);
      tick();
      req0_cmd = 10'h1A5;
      settle();
      chk_ready("lock_wr", 1'b1, 1'b0);
      chk("lock_busy", 32'(busy), 32'd1);
      chk("lock_owner", 32'(owner), 32'd0);
      expect_fwd(10'h1A5);
      tick();
      settle();
      chk("wr_done_state", 32'(dbg_state), 32'd0);
      chk_ready("cont1", 1'b0, 1'b1);
      expect_fwd(10'h0AA);
      tick();
      req1_cmd = 10'h155;
      settle();
      chk_ready("own1", 1'b0, 1'b1);
      chk("own1_owner", 32'(owner), 32'd1);
      expect_fwd(10'h155);
      tick();
      settle();
      chk_ready("cont2", 1'b1, 1'b0);

      // Read by req0 while req1 keeps asking; req1 stays blocked.
      req0_cmd = 10'h210;
      expect_fwd(10'h210);
      tick();
      req0_cmd = 10'h300;
      settle();
      chk_ready("rd_lock", 1'b1, 1'b0);
      expect_fwd(10'h300);
      tick();
      req0_valid = 1'b0;
      settle();
      chk_ready("rd_wait", 1'b0, 1'b0);
      chk("rd_wait_state", 32'(dbg_state), 32'd2);
      tick();
      ram_tx_valid = 1'b1; ram_dout = 8'h33;
      expect_rd(1'b0, 8'h33, cyc + 1);
      tick();
      ram_tx_valid = 1'b0;
      settle();
      chk_ready("rd_done", 1'b0, 1'b1);

      // Read by req1 with data two cycles after the forward.
      req1_cmd = 10'h220;
      expect_fwd(10'h220);
      tick();
      req1_cmd = 10'h300;
      expect_fwd(10'h300);
      tick();
      req1_valid = 1'b0;
      tick(); tick();
      ram_tx_valid = 1'b1; ram_dout = 8'h5C;
      expect_rd(1'b1, 8'h5C, cyc + 1);
      tick();
      ram_tx_valid = 1'b0;
      tick(); tick();
      chk("hold_rdata1", 32'(req1_rdata), 32'h5C);
      chk("hold_rdata0", 32'(req0_rdata), 32'h33);

      // Bare read-data from IDLE, left to time out, then a late return.
      req0_valid = 1'b1; req0_cmd = 10'h3C3;
      expect_fwd(10'h3C3);
      tick();
      req0_valid = 1'b0;
      exp_tmo_q.push_back(cyc + TMO);
      for (int i = 0; i < TMO + 1; i++) tick();
      chk("tmo_busy", 32'(busy), 32'd0);
      ram_tx_valid = 1'b1; ram_dout = 8'hEE;
      tick();
      ram_tx_valid = 1'b0;
      tick();
      chk("tmo_rdata0", 32'(req0_rdata), 32'h33);

      // Data arriving on the last cycle before the timeout wins.
      req0_valid = 1'b1; req0_cmd = 10'h300;
      req1_valid = 1'b1; req1_cmd = 10'h311;
      settle();
      chk_ready("rr_after_tmo", 1'b0, 1'b1);
      expect_fwd(10'h311);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (int i = 0; i < TMO - 1; i++) tick();
      ram_tx_valid = 1'b1; ram_dout = 8'h77;
      expect_rd(1'b1, 8'h77, cyc + 1);
      tick();
      ram_tx_valid = 1'b0;
      tick();

      // Reset while req1 waits on a read; req0 then wins contention.
      req0_valid = 1'b1; req0_cmd = 10'h005;
      expect_fwd(10'h005);
      tick();
      req0_cmd = 10'h100;
      expect_fwd(10'h100);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_cmd = 10'h3F0;
      settle();
      chk_ready("pre_rst", 1'b0, 1'b1);
      expect_fwd(10'h3F0);
      tick();
      req1_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      settle();
      chk_reset_state("mid_rst");
      ram_tx_valid = 1'b1; ram_dout = 8'h99;
      tick();
      ram_tx_valid = 1'b0;
      req0_valid = 1'b1; req0_cmd = 10'h100;
      req1_valid = 1'b1; req1_cmd = 10'h100;
      settle();
      chk_ready("post_rst", 1'b1, 1'b0);
      expect_fwd(10'h100);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick(); tick();

      f = exp_rx_q.size();
      chk("rx_pending", 32'(f), 32'd0);
      f = exp_rd_q.size();
      chk("rd_pending", 32'(f), 32'd0);
      f = exp_tmo_q.size();
      chk("tmo_pending", 32'(f), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
